// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - LC-3b pipeline latch sequencer: load/bubble/flush strobes from memory, load-use and redirect hazards.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 16,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic [REG_IDX_W-1:0] id_sr1,
    input  logic [REG_IDX_W-1:0] id_sr2,
    input  logic                 id_use1,
    input  logic                 id_use2,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 br_taken,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 bubble_id_ex,
    output logic                 bubble_ex_mem,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic dmem_stall;
    logic run_eval;
    logic lu_hit;
    logic redir_acc;
    logic lu_stall;

    logic pc_c, if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
    logic flush_c, bub_id_ex_c, bub_ex_mem_c;

    // DMEM_WAIT behaves like RUN once the stall has cleared; only REDIRECT masks br_taken and load-use.
    assign dmem_stall = dmem_req & ~dmem_resp;
    assign run_eval   = (state_q != REDIRECT);
    assign lu_hit     = ex_is_load & ((id_use1 & (id_sr1 == ex_dest)) |
                                      (id_use2 & (id_sr2 == ex_dest)));
    assign redir_acc  = run_eval & br_taken & ~dmem_stall;
    assign lu_stall   = run_eval & ~br_taken & ~dmem_stall & lu_hit;

    always_comb begin
        pc_c         = 1'b0;
        if_id_c      = 1'b0;
        id_ex_c      = 1'b0;
        ex_mem_c     = 1'b0;
        mem_wb_c     = 1'b0;
        flush_c      = 1'b0;
        bub_id_ex_c  = 1'b0;
        bub_ex_mem_c = 1'b0;
        state_d      = state_q;
        if (dmem_stall) begin
            if (state_q == RUN) begin
                state_d = DMEM_WAIT;
            end
        end else if (redir_acc) begin
            pc_c         = 1'b1;
            if_id_c      = 1'b1;
            id_ex_c      = 1'b1;
            ex_mem_c     = 1'b1;
            mem_wb_c     = 1'b1;
            flush_c      = 1'b1;
            bub_id_ex_c  = 1'b1;
            bub_ex_mem_c = 1'b1;
            state_d      = REDIRECT;
        end else if (lu_stall || !imem_resp) begin
            // Front end holds, a bubble enters EX, back end drains.
            id_ex_c     = 1'b1;
            bub_id_ex_c = 1'b1;
            ex_mem_c    = 1'b1;
            mem_wb_c    = 1'b1;
            state_d     = (state_q == REDIRECT) ? REDIRECT : RUN;
        end else begin
            pc_c     = 1'b1;
            if_id_c  = 1'b1;
            id_ex_c  = 1'b1;
            ex_mem_c = 1'b1;
            mem_wb_c = 1'b1;
            state_d  = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign load_pc       = rst_n & pc_c;
    assign load_if_id    = rst_n & if_id_c;
    assign load_id_ex    = rst_n & id_ex_c;
    assign load_ex_mem   = rst_n & ex_mem_c;
    assign load_mem_wb   = rst_n & mem_wb_c;
    assign flush_if_id   = rst_n & flush_c;
    assign bubble_id_ex  = rst_n & bub_id_ex_c;
    assign bubble_ex_mem = rst_n & bub_ex_mem_c;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((dmem_stall || lu_stall) && (stall_q != {CNT_WIDTH{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (redir_acc && (flush_q != {CNT_WIDTH{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl (directed vectors).
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Strobe vector: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, bubble_id_ex, bubble_ex_mem}
    localparam logic [7:0] ZERO  = 8'b00000_000;
    localparam logic [7:0] NORM  = 8'b11111_000;
    localparam logic [7:0] REDIR = 8'b11111_111;
    localparam logic [7:0] HOLD  = 8'b00111_010;

    typedef struct {
        logic [7:0] v;
        int         st;
        int         fl;
        string      nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_resp, dmem_req, dmem_resp;
    logic [2:0]  id_sr1, id_sr2, ex_dest;
    logic        id_use1, id_use2, ex_is_load, br_taken;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, bubble_id_ex, bubble_ex_mem;
    logic [15:0] stall_cycles, flush_count;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_WIDTH(16), .REG_IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_is_load(ex_is_load), .ex_dest(ex_dest), .br_taken(br_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .bubble_ex_mem(bubble_ex_mem),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Monitor: one DUT response per cycle, compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   flush_if_id, bubble_id_ex, bubble_ex_mem};
            checks = checks + 3;
            if (act !== e.v) begin
                failures = failures + 1;
                $display("FAIL %s strobes: got %b expected %b", e.nm, act, e.v);
            end
            if (stall_cycles !== 16'(e.st)) begin
                failures = failures + 1;
                $display("FAIL %s stall_cycles: got %0d expected %0d", e.nm, stall_cycles, e.st);
            end
            if (flush_count !== 16'(e.fl)) begin
                failures = failures + 1;
                $display("FAIL %s flush_count: got %0d expected %0d", e.nm, flush_count, e.fl);
            end
        end
    end

    task automatic full(input bit rst, input bit im, input bit dq, input bit dr, input bit br,
                        input bit ld, input logic [2:0] dest, input logic [2:0] s1,
                        input logic [2:0] s2, input bit u1, input bit u2,
                        input logic [7:0] ev, input int est, input int efl, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = rst;
        imem_resp  = im;
        dmem_req   = dq;
        dmem_resp  = dr;
        br_taken   = br;
        ex_is_load = ld;
        ex_dest    = dest;
        id_sr1     = s1;
        id_sr2     = s2;
        id_use1    = u1;
        id_use2    = u2;
        e.v  = ev;
        e.st = PERF ? est : 0;
        e.fl = PERF ? efl : 0;
        e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit im, input bit dq, input bit dr, input bit br,
                        input logic [7:0] ev, input int est, input int efl, input string nm);
        full(rst, im, dq, dr, br, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, ev, est, efl, nm);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        br_taken = 1'b0; ex_is_load = 1'b0; ex_dest = 3'd0;
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;

        // rst, imem, dreq, dresp, br
        step(0, 1, 0, 0, 0, ZERO, 0, 0, "reset0");
        step(0, 1, 0, 0, 1, ZERO, 0, 0, "reset1");
        step(1, 1, 0, 0, 0, NORM, 0, 0, "run0");
        step(1, 1, 0, 0, 0, NORM, 0, 0, "run1");
        step(1, 1, 0, 0, 0, NORM, 0, 0, "run2");

        step(1, 1, 1, 0, 0, ZERO, 0, 0, "dwait0");
        step(1, 1, 1, 0, 0, ZERO, 1, 0, "dwait1");
        step(1, 1, 1, 0, 0, ZERO, 2, 0, "dwait2");
        step(1, 1, 1, 1, 0, NORM, 3, 0, "dresp");
        step(1, 1, 0, 0, 0, NORM, 3, 0, "post_dmem");

        full(1, 1, 0, 0, 0, 1, 3'd3, 3'd5, 3'd3, 1'b0, 1'b1, HOLD, 3, 0, "loaduse_sr2");
        step(1, 1, 0, 0, 0, NORM, 4, 0, "after_lu");
        full(1, 1, 0, 0, 0, 1, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0, NORM, 4, 0, "lu_unused");
        full(1, 1, 0, 0, 0, 1, 3'd6, 3'd6, 3'd1, 1'b1, 1'b0, HOLD, 4, 0, "loaduse_sr1");
        full(1, 1, 0, 0, 0, 0, 3'd6, 3'd6, 3'd6, 1'b1, 1'b1, NORM, 5, 0, "not_load");
        step(1, 0, 0, 0, 0, HOLD, 5, 0, "fetch_stall");

        step(1, 0, 0, 0, 1, REDIR, 5, 0, "redir");
        step(1, 0, 0, 0, 1, HOLD, 5, 1, "redir_wait0");
        step(1, 0, 0, 0, 1, HOLD, 5, 1, "redir_wait1");
        step(1, 1, 0, 0, 1, NORM, 5, 1, "redir_resp");
        step(1, 1, 0, 0, 1, REDIR, 5, 1, "redir2");
        step(1, 1, 0, 0, 0, NORM, 5, 2, "redir2_resp");

        step(1, 1, 1, 0, 1, ZERO, 5, 2, "br_vs_dmem");
        step(1, 0, 1, 1, 1, REDIR, 6, 2, "br_on_dresp");
        step(1, 0, 1, 0, 0, ZERO, 6, 3, "redir_freeze");
        step(1, 0, 0, 0, 1, HOLD, 7, 3, "redir_kept");
        full(1, 1, 0, 0, 0, 1, 3'd2, 3'd2, 3'd2, 1'b1, 1'b1, NORM, 7, 3, "redir_lu_ignored");
        step(1, 1, 0, 0, 0, NORM, 7, 3, "back_run");

        step(1, 1, 1, 0, 0, ZERO, 7, 3, "dwait_pre_rst");
        step(0, 1, 0, 0, 0, ZERO, 0, 0, "rst_mid_wait");
        step(1, 1, 0, 0, 0, NORM, 0, 0, "rst_release");
        step(1, 1, 0, 0, 1, REDIR, 0, 0, "run_after_rst");
        step(1, 1, 0, 0, 0, NORM, 0, 1, "final");

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
